// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - per-frame fade-in / bounce / fade-out scene controller
module scene_sequencer #(
    parameter int X0         = 100,
    parameter int Y0         = 100,
    parameter int X_MIN      = 10,
    parameter int X_MAX      = 280,
    parameter int Y_MIN      = 10,
    parameter int Y_MAX      = 420,
    parameter int FADE_DIV   = 16,
    parameter int RUN_FRAMES = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [1:0]  speed,
    input  logic        pause,
    input  logic        restart,
    output logic [8:0]  tx,
    output logic [8:0]  ty,
    output logic [1:0]  fade_level,
    output logic [1:0]  state,
    output logic        corner_pulse,
    output logic [15:0] frame_cnt
);

    localparam logic [8:0] X0_P     = 9'(X0);
    localparam logic [8:0] Y0_P     = 9'(Y0);
    localparam logic [9:0] X_MIN_P  = 10'(X_MIN);
    localparam logic [9:0] X_MAX_P  = 10'(X_MAX);
    localparam logic [9:0] Y_MIN_P  = 10'(Y_MIN);
    localparam logic [9:0] Y_MAX_P  = 10'(Y_MAX);
    localparam logic [7:0] DIV_LAST = 8'(FADE_DIV - 1);
    localparam logic [9:0] RUN_LAST = 10'(RUN_FRAMES - 1);

    typedef enum logic [1:0] {
        FADE_IN  = 2'd0,
        RUN      = 2'd1,
        FADE_OUT = 2'd2
    } scene_t;

    scene_t     scene;
    logic       x_dir, y_dir;
    logic [7:0] div;
    logic [9:0] run_cnt;
    logic [9:0] step;
    logic [8:0] x_next, y_next;
    logic       x_dir_next, y_dir_next, x_hit, y_hit;

    // Returns {clamped, new_dir, new_pos}; all arithmetic in 10 bits so pos+s cannot wrap.
    function automatic logic [10:0] bounce(input logic [8:0] pos, input logic dir,
                                           input logic [9:0] s, input logic [9:0] lo,
                                           input logic [9:0] hi);
        logic [9:0] p;
        logic [9:0] sum;
        logic [9:0] diff;
        p    = {1'b0, pos};
        sum  = p + s;
        diff = p - s;
        if (!dir) begin
            if (sum >= hi) return {1'b1, 1'b1, hi[8:0]};
            else           return {1'b0, 1'b0, sum[8:0]};
        end else begin
            if (p <= lo + s) return {1'b1, 1'b0, lo[8:0]};
            else             return {1'b0, 1'b1, diff[8:0]};
        end
    endfunction

    always_comb begin
        step = {8'd0, speed} + 10'd1;
        {x_hit, x_dir_next, x_next} = bounce(tx, x_dir, step, X_MIN_P, X_MAX_P);
        {y_hit, y_dir_next, y_next} = bounce(ty, y_dir, step, Y_MIN_P, Y_MAX_P);
    end

    assign state = scene;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scene        <= FADE_IN;
            tx           <= X0_P;
            ty           <= Y0_P;
            x_dir        <= 1'b0;
            y_dir        <= 1'b0;
            fade_level   <= 2'd0;
            div          <= 8'd0;
            run_cnt      <= 10'd0;
            corner_pulse <= 1'b0;
            frame_cnt    <= 16'd0;
        end else begin
            corner_pulse <= 1'b0;
            if (frame_tick)
                frame_cnt <= frame_cnt + 16'd1;

            if (restart) begin
                scene      <= FADE_IN;
                fade_level <= 2'd0;
                div        <= 8'd0;
                run_cnt    <= 10'd0;
                tx         <= X0_P;
                ty         <= Y0_P;
                x_dir      <= 1'b0;
                y_dir      <= 1'b0;
            end else if (frame_tick && !pause) begin
                if (scene != FADE_IN) begin
                    tx           <= x_next;
                    ty           <= y_next;
                    x_dir        <= x_dir_next;
                    y_dir        <= y_dir_next;
                    corner_pulse <= x_hit && y_hit;
                end
                case (scene)
                    FADE_IN: begin
                        if (div == DIV_LAST) begin
                            div <= 8'd0;
                            if (fade_level != 2'd3) begin
                                fade_level <= fade_level + 2'd1;
                            end else begin
                                scene   <= RUN;
                                run_cnt <= 10'd0;
                            end
                        end else begin
                            div <= div + 8'd1;
                        end
                    end
                    RUN: begin
                        if (run_cnt == RUN_LAST) begin
                            scene <= FADE_OUT;
                            div   <= 8'd0;
                        end else begin
                            run_cnt <= run_cnt + 10'd1;
                        end
                    end
                    FADE_OUT: begin
                        if (div == DIV_LAST) begin
                            div <= 8'd0;
                            if (fade_level != 2'd0) begin
                                fade_level <= fade_level - 2'd1;
                            end else begin
                                // Scene wraps: the reload overrides this tick's motion.
                                scene        <= FADE_IN;
                                tx           <= X0_P;
                                ty           <= Y0_P;
                                x_dir        <= 1'b0;
                                y_dir        <= 1'b0;
                                corner_pulse <= 1'b0;
                            end
                        end else begin
                            div <= div + 8'd1;
                        end
                    end
                    default: scene <= FADE_IN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scene_sequencer.sv
// tb/tb_scene_sequencer.sv - randomized bench for scene_sequencer against a tick-count scene model
module tb_scene_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       pause = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] speed = 2'd0;

    logic [8:0]  tx0, ty0, tx1, ty1;
    logic [1:0]  fade0, fade1, st0, st1;
    logic        corner0, corner1;
    logic [15:0] fc0, fc1;

    always #5 clk = ~clk;

    scene_sequencer u0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .speed(speed),
        .pause(pause), .restart(restart), .tx(tx0), .ty(ty0),
        .fade_level(fade0), .state(st0), .corner_pulse(corner0), .frame_cnt(fc0)
    );

    scene_sequencer #(.X_MAX(280), .Y_MAX(280)) u1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .speed(speed),
        .pause(pause), .restart(restart), .tx(tx1), .ty(ty1),
        .fade_level(fade1), .state(st1), .corner_pulse(corner1), .frame_cnt(fc1)
    );

    localparam int F     = 16;
    localparam int R     = 600;
    localparam int T_RUN = 4 * F;
    localparam int T_OUT = 4 * F + R;
    localparam int T_END = 8 * F + R;

    int n_checks = 0;
    int n_errors = 0;

    // Scene model: k = active ticks since the scene (re)started.
    int k;
    int fcnt;
    int px[2], py[2], dx[2], dy[2], cp[2];
    int xmax[2] = '{280, 280};
    int ymax[2] = '{420, 280};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_state(input int kk);
        if (kk < T_RUN) return 0;
        if (kk < T_OUT) return 1;
        return 2;
    endfunction

    function automatic int exp_fade(input int kk);
        if (kk < T_RUN) return (kk / F > 3) ? 3 : kk / F;
        if (kk < T_OUT) return 3;
        return 3 - (kk - T_OUT) / F;
    endfunction

    task automatic home();
        for (int i = 0; i < 2; i++) begin
            px[i] = 100; py[i] = 100; dx[i] = 0; dy[i] = 0;
        end
    endtask

    task automatic axis(inout int pos, inout int dir, input int s, input int lo,
                        input int hi, output int hit);
        hit = 0;
        if (dir == 0) begin
            if (pos + s >= hi) begin pos = hi; dir = 1; hit = 1; end
            else pos = pos + s;
        end else begin
            if (pos <= lo + s) begin pos = lo; dir = 0; hit = 1; end
            else pos = pos - s;
        end
    endtask

    task automatic compare_all();
        check("tx0", 32'(tx0), 32'(px[0]));
        check("ty0", 32'(ty0), 32'(py[0]));
        check("tx1", 32'(tx1), 32'(px[1]));
        check("ty1", 32'(ty1), 32'(py[1]));
        check("fade0", 32'(fade0), 32'(exp_fade(k)));
        check("fade1", 32'(fade1), 32'(exp_fade(k)));
        check("state0", 32'(st0), 32'(exp_state(k)));
        check("state1", 32'(st1), 32'(exp_state(k)));
        check("corner0", 32'(corner0), 32'(cp[0]));
        check("corner1", 32'(corner1), 32'(cp[1]));
        check("frame_cnt0", 32'(fc0), 32'(fcnt));
        check("frame_cnt1", 32'(fc1), 32'(fcnt));
    endtask

    task automatic cyc(input bit ft, input bit ps, input bit rs, input int sp);
        int hx, hy;
        @(negedge clk);
        frame_tick = ft; pause = ps; restart = rs; speed = 2'(sp);
        @(posedge clk);
        cp[0] = 0; cp[1] = 0;
        if (ft) fcnt = (fcnt + 1) % 65536;
        if (rs) begin
            k = 0;
            home();
        end else if (ft && !ps) begin
            k++;
            if (k > T_RUN && k < T_END) begin
                for (int i = 0; i < 2; i++) begin
                    axis(px[i], dx[i], sp + 1, 10, xmax[i], hx);
                    axis(py[i], dy[i], sp + 1, 10, ymax[i], hy);
                    cp[i] = (hx != 0 && hy != 0) ? 1 : 0;
                end
            end
            if (k == T_END) begin
                k = 0;
                home();
            end
        end
        #1 compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; frame_tick = 1'b0; pause = 1'b0; restart = 1'b0;
        k = 0; fcnt = 0; cp[0] = 0; cp[1] = 0;
        home();
        #1 compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 compare_all();
    endtask

    initial begin
        int fc_save, tx_save, ty_save;
        do_reset();
        check("reset_tx", 32'(tx0), 32'd100);
        check("reset_ty", 32'(ty0), 32'd100);
        check("reset_fade", 32'(fade0), 32'd0);
        check("reset_state", 32'(st0), 32'd0);
        check("reset_frame_cnt", 32'(fc0), 32'd0);
        check("reset_corner", 32'(corner0), 32'd0);

        for (int t = 1; t <= 64; t++) begin
            cyc(1, 0, 0, 0);
            if (t == 16) check("fade_at16", 32'(fade0), 32'd1);
            if (t == 32) check("fade_at32", 32'(fade0), 32'd2);
            if (t == 48) check("fade_at48", 32'(fade0), 32'd3);
            if (t == 63) check("state_at63", 32'(st0), 32'd0);
            check("fadein_tx_hold", 32'(tx0), 32'd100);
        end
        check("state_at64", 32'(st0), 32'd1);

        for (int t = 1; t <= 81; t++) begin
            cyc(1, 0, 0, 3);
            if (t == 44) check("bounce_tx44", 32'(tx0), 32'd276);
            if (t == 45) begin
                check("bounce_tx45", 32'(tx0), 32'd280);
                check("corner_hit", 32'(corner1), 32'd1);
                cyc(0, 0, 0, 3);
                check("corner_one_cycle", 32'(corner1), 32'd0);
            end
            if (t == 46) check("bounce_tx46", 32'(tx0), 32'd276);
            if (t == 80) check("bounce_ty80", 32'(ty0), 32'd420);
            if (t == 81) check("bounce_ty81", 32'(ty0), 32'd416);
        end

        fc_save = fcnt; tx_save = px[0]; ty_save = py[0];
        for (int t = 0; t < 20; t++) cyc(1, 1, 0, $urandom_range(0, 3));
        check("pause_frame_cnt", 32'(fc0), 32'(fc_save + 20));
        check("pause_tx", 32'(tx0), 32'(tx_save));
        check("pause_ty", 32'(ty0), 32'(ty_save));
        check("pause_state", 32'(st0), 32'd1);

        do_reset();
        for (int t = 0; t < 164; t++) cyc(1, 0, 0, 0);
        check("pre_restart_tx", 32'(tx0), 32'd200);
        cyc(1, 0, 1, 0);
        check("restart_state", 32'(st0), 32'd0);
        check("restart_tx", 32'(tx0), 32'd100);
        check("restart_ty", 32'(ty0), 32'd100);
        check("restart_fade", 32'(fade0), 32'd0);
        check("restart_frame_cnt", 32'(fc0), 32'd165);

        do_reset();
        for (int t = 1; t <= T_END; t++) begin
            cyc(1, 0, 0, $urandom_range(0, 3));
            if (t == 663) check("cycle_state663", 32'(st0), 32'd1);
            if (t == 664) check("cycle_state664", 32'(st0), 32'd2);
            if (t == 727) check("cycle_state727", 32'(st0), 32'd2);
        end
        check("cycle_state728", 32'(st0), 32'd0);
        check("cycle_tx728", 32'(tx0), 32'd100);

        do_reset();
        for (int c = 0; c < 6000; c++) begin
            cyc(($urandom % 3) == 0, ($urandom % 10) == 0, ($urandom % 1500) == 0,
                $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
